// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box tables, Rcon, GF(2^8) helpers and state typedefs.
// Used by both the encryptor and the decryptor.
package aes_pkg;

    localparam int AES128_NR    = 10;
    localparam int KEYEXP_STEPS = 10;
    localparam int ROUND_STEPS  = AES128_NR + 1;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } dec_fsm_e;

    // Entry 0 sits in the top byte of each table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic byte_t inv_sbox(input byte_t b);
        return INV_SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic byte_t rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 of the FIPS-197 state is the MSB of the 128-bit vector.
    function automatic byte_t get_byte(input state_t s, input int i);
        return s[(15 - i) * 8 +: 8];
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// last_i skips InvMixColumns for the final round.
module aes_dec_round
    import aes_pkg::*;
(
    input  state_t state_i,
    input  state_t key_i,
    input  logic   last_i,
    output state_t state_o
);

    byte_t isb [16];
    byte_t ark [16];
    byte_t imc [16];

    always_comb begin
        isb     = '{default: 8'h00};
        ark     = '{default: 8'h00};
        imc     = '{default: 8'h00};
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            // Row i%4 rotates right by its row index.
            isb[i] = inv_sbox(get_byte(state_i, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)));
            ark[i] = isb[i] ^ get_byte(key_i, i);
        end
        for (int c = 0; c < 4; c++) begin
            imc[4*c]   = gmul(ark[4*c], 8'h0e) ^ gmul(ark[4*c+1], 8'h0b) ^
                         gmul(ark[4*c+2], 8'h0d) ^ gmul(ark[4*c+3], 8'h09);
            imc[4*c+1] = gmul(ark[4*c], 8'h09) ^ gmul(ark[4*c+1], 8'h0e) ^
                         gmul(ark[4*c+2], 8'h0b) ^ gmul(ark[4*c+3], 8'h0d);
            imc[4*c+2] = gmul(ark[4*c], 8'h0d) ^ gmul(ark[4*c+1], 8'h09) ^
                         gmul(ark[4*c+2], 8'h0e) ^ gmul(ark[4*c+3], 8'h0b);
            imc[4*c+3] = gmul(ark[4*c], 8'h0b) ^ gmul(ark[4*c+1], 8'h0d) ^
                         gmul(ark[4*c+2], 8'h09) ^ gmul(ark[4*c+3], 8'h0e);
        end
        for (int i = 0; i < 16; i++) begin
            state_o[(15 - i) * 8 +: 8] = last_i ? ark[i] : imc[i];
        end
    end

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then one inverse round per clock
// with round keys walked backwards on the fly. Handshake: a request is taken on a rising edge
// where data_valid_in=1 and ready_out=1; res_valid_out pulses one cycle with res_dec_out valid.
module aes_dec
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         ready_out,
    output logic         res_valid_out,
    output logic [127:0] res_dec_out,
    output logic [1:0]   dbg_state_out
);

    localparam logic [3:0] KEY_LAST   = 4'(KEYEXP_STEPS - 1);
    localparam logic [3:0] ROUND_LAST = 4'(ROUND_STEPS - 1);

    dec_fsm_e   fsm_q;
    logic [3:0] cnt_q;
    state_t     state_q;
    state_t     key_q;
    logic       ready_q;
    logic       res_valid_q;
    state_t     res_q;

    word_t  w0, w1, w2, w3;
    word_t  f0, f1, f2, f3;
    word_t  v0, v1, v2, v3;
    state_t key_fwd_d;
    state_t key_inv_d;
    state_t round_d;

    assign {w0, w1, w2, w3} = key_q;

    assign f0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon(cnt_q + 4'd1), 24'h000000};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign key_fwd_d = {f0, f1, f2, f3};

    // Undo one schedule step: recover w1..w3 first, then w0 from the recovered w3.
    assign v3 = w3 ^ w2;
    assign v2 = w2 ^ w1;
    assign v1 = w1 ^ w0;
    assign v0 = w0 ^ sub_word(rot_word(v3)) ^ {rcon(4'(NR) - cnt_q), 24'h000000};
    assign key_inv_d = {v0, v1, v2, v3};

    aes_dec_round u_round (
        .state_i (state_q),
        .key_i   (key_q),
        .last_i  (cnt_q == ROUND_LAST),
        .state_o (round_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 4'd0;
            state_q     <= '0;
            key_q       <= '0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        state_q <= data_in;
                        key_q   <= key_in;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b0;
                        fsm_q   <= ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    key_q <= key_fwd_d;
                    if (cnt_q == KEY_LAST) begin
                        cnt_q <= 4'd0;
                        fsm_q <= ST_ROUND;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= state_q ^ key_q;
                        key_q   <= key_inv_d;
                        cnt_q   <= cnt_q + 4'd1;
                    end else if (cnt_q == ROUND_LAST) begin
                        res_q       <= round_d;
                        res_valid_q <= 1'b1;
                        cnt_q       <= 4'd0;
                        fsm_q       <= ST_DONE;
                    end else begin
                        state_q <= round_d;
                        key_q   <= key_inv_d;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    fsm_q   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    fsm_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out     = ready_q;
    assign res_valid_out = res_valid_q;
    assign res_dec_out   = res_q;
    assign dbg_state_out = fsm_q;

endmodule

// File: tb/tb_aes_dec.sv
// Self-checking bench for aes_dec: independent forward-cipher model produces ciphertexts,
// expected plaintexts are queued at acceptance and compared when the result pulse arrives.
module tb_aes_dec;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_valid_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         ready_out;
    logic         res_valid_out;
    logic [127:0] res_dec_out;
    logic [1:0]   dbg_state_out;

    aes_dec dut (
        .clk           (clk),
        .reset         (reset),
        .data_valid_in (data_valid_in),
        .data_in       (data_in),
        .key_in        (key_in),
        .ready_out     (ready_out),
        .res_valid_out (res_valid_out),
        .res_dec_out   (res_dec_out),
        .dbg_state_out (dbg_state_out)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           model_acc = 0;
    logic         model_busy = 1'b0;
    logic [127:0] last_res = '0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [7:0]   tb_sbox [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                         {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[(3 - i) * 32 +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]],
                       tb_sbox[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[(15 - i) * 8 +: 8] ^ w[i / 4][(3 - (i % 4)) * 8 +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++)
                t[i] = tb_sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4 * r + i / 4][(3 - (i % 4)) * 8 +: 8];
        end
        for (int i = 0; i < 16; i++) out[(15 - i) * 8 +: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: check outputs against the model, then drive inputs for the next edge.
    task automatic tick(input logic v, input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] pt, output logic acc);
        logic exp_valid;
        logic exp_ready;
        exp_valid = (acc_q.size() > 0) && (cyc == acc_q[0] + 21);
        check_eq("res_valid", 128'(res_valid_out), 128'(exp_valid));
        if (exp_valid) begin
            last_res = exp_q.pop_front();
            void'(acc_q.pop_front());
            check_eq("res_dec", res_dec_out, last_res);
        end else begin
            check_eq("res_hold", res_dec_out, last_res);
        end
        exp_ready = !model_busy || (cyc >= model_acc + 22);
        check_eq("ready", 128'(ready_out), 128'(exp_ready));
        acc = v && exp_ready;
        if (acc) begin
            model_busy = 1'b1;
            model_acc  = cyc + 1;
            exp_q.push_back(pt);
            acc_q.push_back(cyc + 1);
        end
        data_valid_in = v;
        data_in       = d;
        key_in        = k;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 'x, 'x, '0, acc);
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) tick(1'b1, ct, key, pt, acc);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, "_valid"}, 128'(res_valid_out), 128'd0);
        check_eq({tag, "_res"}, res_dec_out, 128'd0);
        check_eq({tag, "_ready"}, 128'(ready_out), 128'd1);
        check_eq({tag, "_state"}, 128'(dbg_state_out), 128'd0);
        exp_q.delete();
        acc_q.delete();
        model_busy = 1'b0;
        last_res   = '0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
    endtask

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] P2  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] C2  = 128'h29C3505F571420F6402299B31A02D73A;

    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        logic         acc;
        reset         = 1'b1;
        data_valid_in = 1'b0;
        data_in       = '0;
        key_in        = '0;
        build_sbox();
        check_eq("model_c1", enc(P1, K1), C1);
        check_eq("model_c2", enc(P2, K2), C2);

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 128'(res_valid_out), 128'd0);
        check_eq("rst_res", res_dec_out, 128'd0);
        check_eq("rst_ready", 128'(ready_out), 128'd1);
        check_eq("rst_state", 128'(dbg_state_out), 128'd0);
        reset = 1'b0;
        cyc   = 0;

        idle(3);
        send(P1, K1, C1);
        idle(30);
        send(P2, K2, C2);
        idle(25);

        for (int i = 0; i < 6; i++) begin
            pt  = rand128();
            key = rand128();
            send(pt, key, enc(pt, key));
            idle(22 + $urandom_range(0, 6));
        end

        // Valid held high with fresh data every cycle.
        for (int i = 0; i < 96; i++) begin
            pt  = rand128();
            key = rand128();
            tick(1'b1, enc(pt, key), key, pt, acc);
        end
        idle(30);

        pt  = rand128();
        key = rand128();
        send(pt, key, enc(pt, key));
        for (int i = 0; i < 40 && cyc < model_acc + 15; i++) idle(1);
        do_reset("midrst");
        idle(30);

        send(P1, K1, C1);
        idle(30);
        check_eq("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
